// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 definitions: RX DMA write FSM states, AXI encodings, link K-codes.
package tlk2711_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AW   = 3'd1;
  localparam logic [2:0] ST_W    = 3'd2;
  localparam logic [2:0] ST_B    = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K   = 4096;

  // 8b/10b control characters used by the link framing
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/tlk2711_rx_dma_wr_axi_w_stage.sv
// Single-entry W channel output register; accepts a stream beat only when the slot is free or draining.
module axi_w_stage #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned WBYTE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   active,
  input  logic                   room,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [WBYTE_WIDTH-1:0] in_keep,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [WBYTE_WIDTH-1:0] wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready
);

  assign in_ready = active & room & (~wvalid | wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid <= 1'b0;
      wlast  <= 1'b0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (in_ready & in_valid) begin
      wvalid <= 1'b1;
      wlast  <= in_last;
      wdata  <= in_data;
      wstrb  <= in_keep;
    end else if (wready) begin
      wvalid <= 1'b0;
      wlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/tlk2711_rx_dma_wr.sv
// AXI4 write master draining the TLK2711 RX stream into DDR in 4 KB-safe INCR bursts.
module tlk2711_rx_dma_wr
  import tlk2711_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DLEN_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned WBYTE_WIDTH = 8,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_soft_rst,
  input  logic                           i_wr_cmd_req,
  output logic                           o_wr_cmd_ack,
  input  logic [ADDR_WIDTH+DLEN_WIDTH-1:0] i_wr_cmd_data,
  output logic                           o_dma_wr_ready,
  input  logic                           i_dma_wr_valid,
  input  logic [WBYTE_WIDTH-1:0]         i_dma_wr_keep,
  input  logic [DATA_WIDTH-1:0]          i_dma_wr_data,
  output logic                           o_wr_finish,
  output logic                           o_wr_err,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [7:0]                     m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [WBYTE_WIDTH-1:0]         m_axi_wstrb,
  output logic                           m_axi_wlast,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready
);

  localparam int unsigned BL_W   = DLEN_WIDTH - 3;
  localparam int unsigned BLEN_W = 9;

  logic [2:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BL_W-1:0]       beats_left;
  logic [BLEN_W-1:0]     blen, blen_n, beat_cnt;
  logic                  abort;
  logic [31:0]           room, blen_c;
  logic                  stream_fire, w_last_fire, b_fire;
  logic                  unused_bits;

  // Burst length for the next AW: limited by remaining beats, MAX_BURST and the 4 KB page.
  assign room   = (32'(BOUNDARY_4K) - 32'(addr[11:0])) >> 3;
  assign blen_c = min3(32'(beats_left), 32'(MAX_BURST), room);
  assign blen_n = BLEN_W'(blen_c);

  assign stream_fire   = i_dma_wr_valid & o_dma_wr_ready;
  assign w_last_fire   = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign b_fire        = m_axi_bvalid & m_axi_bready;
  assign m_axi_awsize  = 3'd3;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign unused_bits   = ^{i_wr_cmd_data[DLEN_WIDTH+2:DLEN_WIDTH], i_wr_cmd_data[2:0],
                           blen_c[31:BLEN_W]};

  axi_w_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .WBYTE_WIDTH(WBYTE_WIDTH)
  ) u_w_stage (
    .clk     (clk),
    .rst     (rst),
    .active  (state == ST_W),
    .room    (beat_cnt < blen),
    .in_valid(i_dma_wr_valid),
    .in_data (i_dma_wr_data),
    .in_keep (i_dma_wr_keep),
    .in_last (beat_cnt == (blen - BLEN_W'(1))),
    .in_ready(o_dma_wr_ready),
    .wdata   (m_axi_wdata),
    .wstrb   (m_axi_wstrb),
    .wlast   (m_axi_wlast),
    .wvalid  (m_axi_wvalid),
    .wready  (m_axi_wready)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // The first AW cycle registers the burst (or routes an empty command to DONE).
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (i_wr_cmd_req) state_n = ST_AW;
      ST_AW: begin
        if (!m_axi_awvalid) begin
          if (beats_left == '0) state_n = ST_DONE;
        end else if (m_axi_awready) begin
          state_n = ST_W;
        end
      end
      ST_W:    if (w_last_fire) state_n = ST_B;
      ST_B: begin
        if (b_fire) begin
          if (abort | i_soft_rst)               state_n = ST_IDLE;
          else if (beats_left == BL_W'(blen))   state_n = ST_DONE;
          else                                  state_n = ST_AW;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr_cmd_ack  <= 1'b0;
      o_wr_finish   <= 1'b0;
      o_wr_err      <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      addr          <= '0;
      beats_left    <= '0;
      blen          <= '0;
      beat_cnt      <= '0;
      abort         <= 1'b0;
    end else begin
      o_wr_cmd_ack <= 1'b0;
      o_wr_finish  <= 1'b0;
      if (state != ST_IDLE && i_soft_rst) abort <= 1'b1;
      case (state)
        ST_IDLE: begin
          abort <= 1'b0;
          if (i_soft_rst) o_wr_err <= 1'b0;
          if (i_wr_cmd_req) begin
            o_wr_cmd_ack <= 1'b1;
            addr         <= {i_wr_cmd_data[ADDR_WIDTH+DLEN_WIDTH-1:DLEN_WIDTH+3], 3'b000};
            beats_left   <= i_wr_cmd_data[DLEN_WIDTH-1:3];
          end
        end
        ST_AW: begin
          if (!m_axi_awvalid) begin
            beat_cnt <= '0;
            if (beats_left != '0) begin
              blen          <= blen_n;
              m_axi_awaddr  <= addr;
              m_axi_awlen   <= 8'(blen_n - BLEN_W'(1));
              m_axi_awvalid <= 1'b1;
            end
          end else if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
        end
        ST_W: begin
          if (stream_fire) beat_cnt <= beat_cnt + BLEN_W'(1);
          if (w_last_fire) m_axi_bready <= 1'b1;
        end
        ST_B: begin
          if (b_fire) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) o_wr_err <= 1'b1;
            addr       <= addr + (ADDR_WIDTH'(blen) << 3);
            beats_left <= beats_left - BL_W'(blen);
          end
        end
        ST_DONE: o_wr_finish <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlk2711_rx_dma_wr.sv
// Scoreboard bench for tlk2711_rx_dma_wr: planned AW bursts and accepted stream beats are queued and checked on AXI.
module tb_tlk2711_rx_dma_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_soft_rst, i_wr_cmd_req, o_wr_cmd_ack;
  logic [47:0] i_wr_cmd_data;
  logic        o_dma_wr_ready, i_dma_wr_valid;
  logic [7:0]  i_dma_wr_keep;
  logic [63:0] i_dma_wr_data;
  logic        o_wr_finish, o_wr_err;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int ready_pct = 100, valid_pct = 100, bad_b = -1;
  int aw_count = 0, w_count = 0, b_count = 0, finish_count = 0, pending_b = 0;
  int last_b_cyc = 0, last_finish_cyc = 0, src_idx = 0;
  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  logic [63:0] exp_w_data[$];
  logic [7:0]  exp_w_strb[$];

  tlk2711_rx_dma_wr dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst),
    .i_wr_cmd_req(i_wr_cmd_req), .o_wr_cmd_ack(o_wr_cmd_ack), .i_wr_cmd_data(i_wr_cmd_data),
    .o_dma_wr_ready(o_dma_wr_ready), .i_dma_wr_valid(i_dma_wr_valid),
    .i_dma_wr_keep(i_dma_wr_keep), .i_dma_wr_data(i_dma_wr_data),
    .o_wr_finish(o_wr_finish), .o_wr_err(o_wr_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference burst split: min(beats left, 16, beats to next 4 KB page).
  task automatic plan_cmd(input logic [31:0] saddr, input int len, output int n);
    logic [31:0] a;
    int beats, room, b;
    a = saddr & ~32'h7;
    beats = len >> 3;
    n = 0;
    while (beats > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      b = beats;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(b - 1));
      a = a + 32'(b * 8);
      beats = beats - b;
      n++;
    end
  endtask

  // AXI slave, stream source and scoreboard; drives at negedge, samples just before posedge.
  initial begin : slave
    bit b_hs, w_stall, aw_stall, exp_last;
    logic [63:0] held_d, ed;
    logic [7:0]  held_s, es, el;
    logic        held_l;
    logic [31:0] held_a, ea;
    logic [7:0]  held_len;
    int cur_len, wbeat;
    b_hs = 0; w_stall = 0; aw_stall = 0; cur_len = 0; wbeat = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    i_dma_wr_valid = 0; i_dma_wr_data = '0; i_dma_wr_keep = '0;
    forever begin
      @(negedge clk);
      if (b_hs) m_axi_bvalid = 1'b0;
      b_hs = 0;
      m_axi_awready = ($urandom_range(0, 99) < 32'(ready_pct));
      m_axi_wready  = ($urandom_range(0, 99) < 32'(ready_pct));
      if (!m_axi_bvalid && pending_b > 0 && $urandom_range(0, 99) < 32'(ready_pct)) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_count == bad_b) ? 2'b10 : 2'b00;
      end
      i_dma_wr_valid = ($urandom_range(0, 99) < 32'(valid_pct));
      i_dma_wr_data  = {32'(src_idx) ^ 32'hA5A5_0000, 32'(src_idx) * 32'h0101_0101};
      i_dma_wr_keep  = (src_idx % 5 == 0) ? 8'h0F : 8'hFF;
      #4;
      if (!rst) begin
        if (w_stall) begin
          n_checks++;
          if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== held_d || m_axi_wstrb !== held_s ||
              m_axi_wlast !== held_l) begin
            n_fail++;
            $display("FAIL w_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     m_axi_wvalid, m_axi_wdata, m_axi_wlast, held_d, held_l);
          end
        end
        if (aw_stall) begin
          n_checks++;
          if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== held_a || m_axi_awlen !== held_len) begin
            n_fail++;
            $display("FAIL aw_hold: got valid=%b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                     m_axi_awvalid, m_axi_awaddr, m_axi_awlen, held_a, held_len);
          end
        end
        if (m_axi_awvalid && m_axi_awready) begin
          aw_count++;
          n_checks++;
          if (exp_aw_addr.size() == 0) begin
            n_fail++;
            $display("FAIL aw_unexpected: got addr=%h len=%0d, required no AW", m_axi_awaddr, m_axi_awlen);
          end else begin
            ea = exp_aw_addr.pop_front();
            el = exp_aw_len.pop_front();
            if (m_axi_awaddr !== ea || m_axi_awlen !== el || m_axi_awsize !== 3'd3 ||
                m_axi_awburst !== 2'b01) begin
              n_fail++;
              $display("FAIL aw_fields: got addr=%h len=%0d size=%0d burst=%b, required addr=%h len=%0d size=3 burst=01",
                       m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, ea, el);
            end
          end
          cur_len = int'(m_axi_awlen);
          wbeat = 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_count++;
          exp_last = (wbeat == cur_len);
          n_checks++;
          if (exp_w_data.size() == 0) begin
            n_fail++;
            $display("FAIL w_unexpected: got data=%h, required no W beat", m_axi_wdata);
          end else begin
            ed = exp_w_data.pop_front();
            es = exp_w_strb.pop_front();
            if (m_axi_wdata !== ed || m_axi_wstrb !== es || m_axi_wlast !== exp_last) begin
              n_fail++;
              $display("FAIL w_beat: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                       m_axi_wdata, m_axi_wstrb, m_axi_wlast, ed, es, exp_last);
            end
          end
          if (exp_last) pending_b++;
          wbeat++;
        end
        if (i_dma_wr_valid && o_dma_wr_ready) begin
          exp_w_data.push_back(i_dma_wr_data);
          exp_w_strb.push_back(i_dma_wr_keep);
          src_idx++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_count++;
          pending_b--;
          last_b_cyc = cyc;
          b_hs = 1;
        end
        if (o_wr_finish) begin
          finish_count++;
          last_finish_cyc = cyc;
        end
        w_stall  = m_axi_wvalid && !m_axi_wready;
        held_d   = m_axi_wdata; held_s = m_axi_wstrb; held_l = m_axi_wlast;
        aw_stall = m_axi_awvalid && !m_axi_awready;
        held_a   = m_axi_awaddr; held_len = m_axi_awlen;
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] saddr, input int len, output int ack_cyc);
    int n;
    plan_cmd(saddr, len, n);
    @(negedge clk);
    i_wr_cmd_req  = 1'b1;
    i_wr_cmd_data = {saddr, 16'(len)};
    ack_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_wr_cmd_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    i_wr_cmd_req = 1'b0;
    n_checks++;
    if (ack_cyc < 0) begin
      n_fail++;
      $display("FAIL cmd_ack: got no ack for addr=%h len=%0d, required ack", saddr, len);
    end
  endtask

  task automatic wait_finish(input int base, input int budget);
    int i;
    for (i = 0; i < budget && finish_count <= base; i++) @(negedge clk);
    n_checks++;
    if (finish_count <= base) begin
      n_fail++;
      $display("FAIL finish_timeout: got %0d finish pulses after %0d cycles, required %0d", finish_count - base, budget, 1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_wr_cmd_ack, o_wr_finish, o_wr_err,
         m_axi_wlast, o_dma_wr_ready} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got awv=%b wv=%b br=%b ack=%b fin=%b err=%b wlast=%b rdy=%b, required all 0",
               m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_wr_cmd_ack, o_wr_finish, o_wr_err,
               m_axi_wlast, o_dma_wr_ready);
    end
    n_checks++;
    if (m_axi_awaddr !== 32'h0 || m_axi_awlen !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_aw: got addr=%h len=%0d, required 0 0", m_axi_awaddr, m_axi_awlen);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst;
    int ack, aw0, w0, f0;
    ready_pct = 100; valid_pct = 100;
    aw0 = aw_count; w0 = w_count; f0 = finish_count;
    issue_cmd(32'h1000_0000, 128, ack);
    n_checks++;
    if (m_axi_awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_aw_early: got awvalid=%b in ack cycle, required 0", m_axi_awvalid);
    end
    @(negedge clk);
    n_checks++;
    if (m_axi_awvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_aw_latency: got awvalid=%b one cycle after ack, required 1", m_axi_awvalid);
    end
    wait_finish(f0, 200);
    repeat (3) @(negedge clk);
    n_checks++;
    if (aw_count - aw0 != 1 || w_count - w0 != 16 || finish_count - f0 != 1 || o_wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_counts: got aw=%0d w=%0d fin=%0d err=%b, required 1 16 1 0",
               aw_count - aw0, w_count - w0, finish_count - f0, o_wr_err);
    end
    // B handshake -> DONE -> registered finish
    n_checks++;
    if (last_finish_cyc - last_b_cyc != 2) begin
      n_fail++;
      $display("FAIL single_finish_timing: got finish %0d cycles after B, required 2", last_finish_cyc - last_b_cyc);
    end
  endtask

  task automatic test_4k_cross;
    int ack, aw0, w0, f0;
    ready_pct = 70; valid_pct = 70;
    aw0 = aw_count; w0 = w_count; f0 = finish_count;
    issue_cmd(32'h0000_0FF0, 64, ack);
    wait_finish(f0, 500);
    n_checks++;
    if (aw_count - aw0 != 2 || w_count - w0 != 8 || exp_aw_addr.size() != 0 || exp_w_data.size() != 0) begin
      n_fail++;
      $display("FAIL cross4k_counts: got aw=%0d w=%0d aw_left=%0d w_left=%0d, required 2 8 0 0",
               aw_count - aw0, w_count - w0, exp_aw_addr.size(), exp_w_data.size());
    end
  endtask

  task automatic test_zero_len;
    int ack, aw0, f0;
    ready_pct = 100; valid_pct = 100;
    aw0 = aw_count; f0 = finish_count;
    issue_cmd(32'h0000_1234, 7, ack);
    wait_finish(f0, 20);
    n_checks++;
    if (aw_count != aw0 || last_finish_cyc != ack + 2) begin
      n_fail++;
      $display("FAIL zero_len: got aw=%0d finish at ack+%0d, required aw=0 finish at ack+2",
               aw_count - aw0, last_finish_cyc - ack);
    end
  endtask

  task automatic test_multi_burst;
    int ack, aw0, w0, f0;
    ready_pct = 50; valid_pct = 50;
    aw0 = aw_count; w0 = w_count; f0 = finish_count;
    issue_cmd(32'h2000_0000, 5136, ack);
    wait_finish(f0, 20000);
    repeat (4) @(negedge clk);
    n_checks++;
    if (aw_count - aw0 != 41 || w_count - w0 != 642 || finish_count - f0 != 1 || exp_w_data.size() != 0) begin
      n_fail++;
      $display("FAIL multi_counts: got aw=%0d w=%0d fin=%0d w_left=%0d, required 41 642 1 0",
               aw_count - aw0, w_count - w0, finish_count - f0, exp_w_data.size());
    end
  endtask

  task automatic test_error;
    int ack, b0, f0, i;
    ready_pct = 80; valid_pct = 80;
    b0 = b_count; f0 = finish_count;
    bad_b = b0 + 1;
    issue_cmd(32'h4000_0000, 384, ack);
    for (i = 0; i < 1000 && b_count < b0 + 1; i++) @(negedge clk);
    n_checks++;
    if (b_count < b0 + 1 || o_wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_burst1: got b=%0d err=%b, required b>=1 err=0", b_count - b0, o_wr_err);
    end
    for (i = 0; i < 1000 && b_count < b0 + 2; i++) @(negedge clk);
    n_checks++;
    if (o_wr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_burst2: got err=%b after bad BRESP, required 1", o_wr_err);
    end
    wait_finish(f0, 1000);
    bad_b = -1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_wr_err !== 1'b1 || finish_count - f0 != 1) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b fin=%0d, required err=1 fin=1", o_wr_err, finish_count - f0);
    end
    i_soft_rst = 1'b1;
    @(negedge clk);
    i_soft_rst = 1'b0;
    n_checks++;
    if (o_wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b after idle soft reset, required 0", o_wr_err);
    end
  endtask

  task automatic test_abort;
    int ack, aw0, w0, b0, f0, i;
    ready_pct = 100; valid_pct = 50;
    aw0 = aw_count; w0 = w_count; b0 = b_count; f0 = finish_count;
    issue_cmd(32'h5000_0000, 512, ack);
    for (i = 0; i < 500 && w_count < w0 + 5; i++) @(negedge clk);
    i_soft_rst = 1'b1;
    @(negedge clk);
    i_soft_rst = 1'b0;
    for (i = 0; i < 500 && b_count < b0 + 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks++;
    if (aw_count - aw0 != 1 || w_count - w0 != 16 || b_count - b0 != 1 || finish_count != f0 ||
        m_axi_awvalid !== 1'b0 || exp_aw_addr.size() != 3) begin
      n_fail++;
      $display("FAIL abort_stop: got aw=%0d w=%0d b=%0d fin=%0d awv=%b aw_left=%0d, required 1 16 1 0 0 3",
               aw_count - aw0, w_count - w0, b_count - b0, finish_count - f0, m_axi_awvalid,
               exp_aw_addr.size());
    end
    exp_aw_addr.delete();
    exp_aw_len.delete();
    aw0 = aw_count; f0 = finish_count;
    issue_cmd(32'h5000_0800, 128, ack);
    wait_finish(f0, 500);
    n_checks++;
    if (aw_count - aw0 != 1 || finish_count - f0 != 1) begin
      n_fail++;
      $display("FAIL abort_next_cmd: got aw=%0d fin=%0d, required 1 1", aw_count - aw0, finish_count - f0);
    end
  endtask

  task automatic test_back_to_back;
    int ack, ackb, n, aw0, f0, fin_at_ack;
    ready_pct = 100; valid_pct = 100;
    aw0 = aw_count; f0 = finish_count;
    issue_cmd(32'h6000_0000, 128, ack);
    plan_cmd(32'h6000_1000, 64, n);
    @(negedge clk);
    i_wr_cmd_req  = 1'b1;
    i_wr_cmd_data = {32'h6000_1000, 16'd64};
    ackb = -1;
    fin_at_ack = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_wr_cmd_ack) begin
        ackb = cyc;
        fin_at_ack = finish_count - f0;
        break;
      end
    end
    i_wr_cmd_req = 1'b0;
    n_checks++;
    if (ackb < 0 || fin_at_ack != 1 || ackb != last_finish_cyc + 1) begin
      n_fail++;
      $display("FAIL b2b_ack: got ack_cyc=%0d fin_before=%0d finish_cyc=%0d, required ack one cycle after finish with 1 finish",
               ackb, fin_at_ack, last_finish_cyc);
    end
    wait_finish(f0 + 1, 500);
    n_checks++;
    if (aw_count - aw0 != 1 + n || finish_count - f0 != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: got aw=%0d fin=%0d, required %0d 2", aw_count - aw0, finish_count - f0, 1 + n);
    end
  endtask

  initial begin
    i_soft_rst = 1'b0;
    i_wr_cmd_req = 1'b0;
    i_wr_cmd_data = '0;
    test_reset;
    test_single_burst;
    test_4k_cross;
    test_zero_len;
    test_multi_burst;
    test_error;
    test_abort;
    test_back_to_back;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
